frame_capture_sched: RTL and testbench
======================================

Name: frame_capture_sched

Overview:
- Sequences capture of one video frame into the single-port on-chip frame buffer, then hands that buffer to the pupil-search processor.
- Counts frame starts from the VGA raster coordinates and skips a configurable number of frames after arming.
- Owns the buffer write port and multiplexes it between the capture writer and the processor, so only one requester ever drives memory.
- Sits between the pixel-coordinate generator, the capture writer, the processor and the frame-buffer RAM.

Parameters:
- SOF_X, 143, raster X coordinate that marks start of frame.
- SOF_Y, 34, raster Y coordinate that marks start of frame.
- SKIP_FRAMES, 5, number of whole frames discarded after arming (0..255).
- ADDR_W, 15, frame-buffer address width.
- DATA_W, 10, frame-buffer data width.
- MEM_DEPTH, 19200, valid buffer words (160x120); addresses at or above this are illegal.
- TIMEOUT_FRAMES, 8, processing watchdog limit in frames; used only with the optional feature.

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  asynchronous reset, active-high.
- iX  in  13  raster X.
- iY  in  13  raster Y.
- iArm  in  1  level from the switch; 1 = run captures.
- iCapWE  in  1  capture writer write strobe.
- iCapAddr  in  ADDR_W  capture writer address.
- iCapData  in  DATA_W  capture writer data.
- iProcWE  in  1  processor write strobe.
- iProcAddr  in  ADDR_W  processor address.
- iProcData  in  DATA_W  processor write data.
- iProcDone  in  1  one-cycle pulse: processing finished.
- oCapEnable  out  1  capture writer may write (state CAPTURE).
- oProcGrant  out  1  processor owns memory (state PROCESS).
- oProcStart  out  1  one-cycle pulse on entry to PROCESS.
- oFrameValid  out  1  buffer holds a complete frame.
- oFrameCount  out  8  completed captures, wraps 255->0.
- oMemAddr  out  ADDR_W  RAM address.
- oMemData  out  DATA_W  RAM write data.
- oMemWE  out  1  RAM write enable.
- oLed  out  1  sticky error indicator.

Behaviour:
- Reset: the reset is asynchronous and active-high on iRST, and the block uses the single clock iCLK. During reset all outputs are 0, the state is IDLE and all counters are 0.
- SOF detection: sof = match & ~match_d, where match = (iX==SOF_X && iY==SOF_Y). This gives exactly one pulse per frame even if the coordinate is held for several cycles.
- States: IDLE, SKIP, CAPTURE, PROCESS.
- IDLE -> SKIP when iArm=1; the skip counter clears on entry.
- SKIP: each sof increments the skip counter.
  - On the sof where the count equals SKIP_FRAMES, go to CAPTURE. With SKIP_FRAMES=0 the first sof enters CAPTURE.
  - iArm=0 returns to IDLE.
- CAPTURE: oCapEnable=1; oFrameValid clears on entry.
  - The next sof goes to PROCESS: oFrameValid=1, oFrameCount+1, and oProcStart pulses on the PROCESS entry cycle.
  - iArm=0 mid-capture aborts to IDLE; the partial frame is discarded and oFrameValid stays 0.
- PROCESS: oProcGrant=1. iArm is ignored; processing always completes.
  - iProcDone goes to SKIP if iArm=1, else IDLE.
  - iProcDone in the same cycle as entry to PROCESS is ignored; iProcDone is only honoured while in PROCESS.
- Memory mux: registered, 1-cycle latency from the requester inputs to oMem*.
  - In CAPTURE, the source is the capture writer.
  - In PROCESS, the source is the processor.
  - Otherwise oMemWE=0 and oMemAddr/oMemData hold 0.
  - Inputs from the non-owning requester are ignored completely.
- Address guard: a write with address >= MEM_DEPTH is suppressed (oMemWE=0) and sets oLed sticky. oLed clears only on reset.
- Simultaneous sof and iArm fall in SKIP or CAPTURE: the abort wins.

Optional Feature:
- Macro: FRAME_CAPTURE_PROC_TIMEOUT_EN.
- With the macro defined: PROCESS counts sof pulses. When the count reaches TIMEOUT_FRAMES without iProcDone, the block forces IDLE, clears oProcGrant, sets oLed sticky and clears oFrameValid.
- Without the macro: PROCESS waits indefinitely and the watchdog counter is not synthesised.

Decomposition:
- Shared package frame_capture_pkg holds:
  - the state encoding (IDLE=0, SKIP=1, CAPTURE=2, PROCESS=3);
  - the SOF_X/SOF_Y defaults;
  - the 160x120 resolution constants and MEM_DEPTH.
- One sub-module, sof_detect: coordinate compare, delay register and edge pulse, reused by the capture writer.

Test Plan:
- Reset mid-CAPTURE -> outputs 0 immediately (asynchronously), state IDLE; oFrameCount unchanged at 0 after release.
- iArm=1, SKIP_FRAMES=5 -> oCapEnable rises on the 6th sof after arm, falls on the 7th; oProcStart pulses once; oFrameCount=1.
- Hold SOF coordinate for 4 cycles -> exactly one sof counted.
- CAPTURE with iCapWE=1, iCapAddr=100, iCapData=0x3FF -> next cycle oMemWE=1, oMemAddr=100, oMemData=0x3FF. iProcWE=1 in the same cycle has no effect.
- iCapAddr=19200 with iCapWE=1 -> oMemWE=0, oLed=1 sticky. Drop iArm mid-CAPTURE -> IDLE with oFrameValid=0.
- PROCESS, iProcDone with iArm=1 -> SKIP and a second capture follows (oFrameCount=2). With the timeout macro and no done for 8 sof -> IDLE, oLed=1.

Source files
------------

// File: rtl/frame_capture_pkg.sv
// rtl/frame_capture_pkg.sv - shared state encoding and frame geometry for frame_capture_sched
package frame_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_PROCESS = 2'd3
    } state_t;

    localparam int SOF_X_DEF     = 143;
    localparam int SOF_Y_DEF     = 34;
    localparam int H_RES         = 160;
    localparam int V_RES         = 120;
    localparam int MEM_DEPTH_DEF = H_RES * V_RES;

endpackage

// File: rtl/frame_capture_sched_sof_detect.sv
// rtl/frame_capture_sched_sof_detect.sv - start-of-frame pulse from raster coordinates
module sof_detect #(
    parameter int COORD_W = 13,
    parameter int SOF_X   = 143,
    parameter int SOF_Y   = 34
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               sof
);

    logic match;
    logic match_d;
    logic match_q;

    // Coordinate compare; the edge against the delayed copy yields one pulse
    // per frame however long the raster lingers on the SOF pixel.
    always_comb begin
        match   = (x == COORD_W'(SOF_X)) && (y == COORD_W'(SOF_Y));
        match_d = match;
        sof     = match & ~match_q;
    end

    // Delay register for the edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

endmodule

// File: rtl/frame_capture_sched.sv
// rtl/frame_capture_sched.sv - frame capture sequencer and frame-buffer port owner (option: FRAME_CAPTURE_PROC_TIMEOUT_EN)
module frame_capture_sched
    import frame_capture_pkg::*;
#(
    parameter int SOF_X          = SOF_X_DEF,
    parameter int SOF_Y          = SOF_Y_DEF,
    parameter int SKIP_FRAMES    = 5,
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 10,
    parameter int MEM_DEPTH      = MEM_DEPTH_DEF,
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [12:0]       iX,
    input  logic [12:0]       iY,
    input  logic              iArm,
    input  logic              iCapWE,
    input  logic [ADDR_W-1:0] iCapAddr,
    input  logic [DATA_W-1:0] iCapData,
    input  logic              iProcWE,
    input  logic [ADDR_W-1:0] iProcAddr,
    input  logic [DATA_W-1:0] iProcData,
    input  logic              iProcDone,
    output logic              oCapEnable,
    output logic              oProcGrant,
    output logic              oProcStart,
    output logic              oFrameValid,
    output logic [7:0]        oFrameCount,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemData,
    output logic              oMemWE,
    output logic              oLed
);

    localparam logic [7:0]      SKIP_CMP  = 8'(SKIP_FRAMES);
    localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W+1)'(MEM_DEPTH);

    logic sof;

    state_t            state_d, state_q;
    logic [7:0]        skip_cnt_d, skip_cnt_q;
    logic              frame_valid_d, frame_valid_q;
    logic [7:0]        frame_count_d, frame_count_q;
    logic              proc_start_d, proc_start_q;
    logic              led_d, led_q;
    logic              mem_we_d, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic [DATA_W-1:0] mem_data_d, mem_data_q;

    logic              req_own;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

`ifdef FRAME_CAPTURE_PROC_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_FRAMES - 1);
    logic [7:0] wd_cnt_d, wd_cnt_q;
`endif

    sof_detect #(
        .COORD_W (13),
        .SOF_X   (SOF_X),
        .SOF_Y   (SOF_Y)
    ) u_sof_detect (
        .clk (iCLK),
        .rst (iRST),
        .x   (iX),
        .y   (iY),
        .sof (sof)
    );

    // Sequencer next state plus the frame bookkeeping that moves with it;
    // an arm drop always beats a coincident sof.
    always_comb begin
        state_d       = state_q;
        skip_cnt_d    = skip_cnt_q;
        frame_valid_d = frame_valid_q;
        frame_count_d = frame_count_q;
        proc_start_d  = 1'b0;
`ifdef FRAME_CAPTURE_PROC_TIMEOUT_EN
        wd_cnt_d      = wd_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iArm) begin
                    state_d    = ST_SKIP;
                    skip_cnt_d = 8'd0;
                end
            end
            ST_SKIP: begin
                if (!iArm) begin
                    state_d = ST_IDLE;
                end else if (sof) begin
                    if (skip_cnt_q == SKIP_CMP) begin
                        state_d       = ST_CAPTURE;
                        frame_valid_d = 1'b0;
                    end else begin
                        skip_cnt_d = skip_cnt_q + 8'd1;
                    end
                end
            end
            ST_CAPTURE: begin
                if (!iArm) begin
                    state_d = ST_IDLE;
                end else if (sof) begin
                    state_d       = ST_PROCESS;
                    frame_valid_d = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                    proc_start_d  = 1'b1;
`ifdef FRAME_CAPTURE_PROC_TIMEOUT_EN
                    wd_cnt_d      = 8'd0;
`endif
                end
            end
            ST_PROCESS: begin
                // A done coinciding with the start pulse predates this frame.
                if (iProcDone && !proc_start_q) begin
                    state_d    = iArm ? ST_SKIP : ST_IDLE;
                    skip_cnt_d = 8'd0;
                end
`ifdef FRAME_CAPTURE_PROC_TIMEOUT_EN
                else if (sof) begin
                    if (wd_cnt_q == TIMEOUT_LAST) begin
                        state_d       = ST_IDLE;
                        frame_valid_d = 1'b0;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 8'd1;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Port mux: only the current owner reaches the RAM, out-of-range writes
    // are dropped and latch the error LED.
    always_comb begin
        req_own    = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        mem_data_d = '0;
        led_d      = led_q;
        if (state_q == ST_CAPTURE) begin
            req_own  = 1'b1;
            req_we   = iCapWE;
            req_addr = iCapAddr;
            req_data = iCapData;
        end else if (state_q == ST_PROCESS) begin
            req_own  = 1'b1;
            req_we   = iProcWE;
            req_addr = iProcAddr;
            req_data = iProcData;
        end
        if (req_own) begin
            mem_addr_d = req_addr;
            mem_data_d = req_data;
            if (req_we) begin
                if ({1'b0, req_addr} < DEPTH_CMP) begin
                    mem_we_d = 1'b1;
                end else begin
                    led_d = 1'b1;
                end
            end
        end
`ifdef FRAME_CAPTURE_PROC_TIMEOUT_EN
        if (state_q == ST_PROCESS && !(iProcDone && !proc_start_q) && sof
            && wd_cnt_q == TIMEOUT_LAST) begin
            led_d = 1'b1;
        end
`endif
    end

    // State, counters and registered RAM port.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q       <= ST_IDLE;
            skip_cnt_q    <= 8'd0;
            frame_valid_q <= 1'b0;
            frame_count_q <= 8'd0;
            proc_start_q  <= 1'b0;
            led_q         <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            proc_start_q  <= proc_start_d;
            led_q         <= led_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
        end
    end

`ifdef FRAME_CAPTURE_PROC_TIMEOUT_EN
    // Processing watchdog, counted in frames.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wd_cnt_q <= 8'd0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    assign oCapEnable  = (state_q == ST_CAPTURE);
    assign oProcGrant  = (state_q == ST_PROCESS);
    assign oProcStart  = proc_start_q;
    assign oFrameValid = frame_valid_q;
    assign oFrameCount = frame_count_q;
    assign oMemAddr    = mem_addr_q;
    assign oMemData    = mem_data_q;
    assign oMemWE      = mem_we_q;
    assign oLed        = led_q;

endmodule

// File: tb/tb_frame_capture_sched.sv
// tb/tb_frame_capture_sched.sv - self-checking bench for frame_capture_sched
module tb_frame_capture_sched;

    localparam int SKIP  = 5;
    localparam int DEPTH = 19200;
    localparam int TMO   = 8;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [12:0] iX = '0, iY = '0;
    logic        iArm = 1'b0;
    logic        iCapWE = 1'b0, iProcWE = 1'b0, iProcDone = 1'b0;
    logic [14:0] iCapAddr = '0, iProcAddr = '0;
    logic [9:0]  iCapData = '0, iProcData = '0;
    logic        oCapEnable, oProcGrant, oProcStart, oFrameValid, oMemWE, oLed;
    logic [7:0]  oFrameCount;
    logic [14:0] oMemAddr;
    logic [9:0]  oMemData;

    int checks = 0;
    int failures = 0;
    int starts = 0;
    int exp_count = 0;

    frame_capture_sched dut (
        .iCLK(iCLK), .iRST(iRST), .iX(iX), .iY(iY), .iArm(iArm),
        .iCapWE(iCapWE), .iCapAddr(iCapAddr), .iCapData(iCapData),
        .iProcWE(iProcWE), .iProcAddr(iProcAddr), .iProcData(iProcData),
        .iProcDone(iProcDone),
        .oCapEnable(oCapEnable), .oProcGrant(oProcGrant), .oProcStart(oProcStart),
        .oFrameValid(oFrameValid), .oFrameCount(oFrameCount),
        .oMemAddr(oMemAddr), .oMemData(oMemData), .oMemWE(oMemWE), .oLed(oLed)
    );

    always #5 iCLK = ~iCLK;

    always @(negedge iCLK) if (oProcStart) starts++;

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // One raster frame: SOF coordinate held for 'hold' cycles, then elsewhere.
    task automatic sof_frame(input int hold);
        iX = 13'd143; iY = 13'd34;
        repeat (hold) tick();
        iX = 13'd10; iY = 13'd200;
        tick();
    endtask

    task automatic arm_to_capture();
        iArm = 1'b1;
        tick();
        repeat (SKIP + 1) sof_frame($urandom_range(1, 4));
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        repeat (3) tick();
        checks++;
        if ({oCapEnable, oProcGrant, oProcStart, oFrameValid, oFrameCount, oMemAddr, oMemData, oMemWE, oLed} !== '0) begin
            failures++;
            $display("FAIL reset_outputs actual=%b/%b/%b/%b/%0d/%0d/%0d/%b/%b required=all_zero",
                     oCapEnable, oProcGrant, oProcStart, oFrameValid, oFrameCount, oMemAddr, oMemData, oMemWE, oLed);
        end
        iRST = 1'b0;
        tick();
    endtask

    task automatic test_skip_capture();
        iArm = 1'b1;
        tick();
        for (int i = 1; i <= SKIP + 1; i++) begin
            sof_frame($urandom_range(1, 4));
            checks++;
            if (oCapEnable !== (i == SKIP + 1)) begin
                failures++;
                $display("FAIL cap_enable_after_sof%0d actual=%b required=%b", i, oCapEnable, (i == SKIP + 1));
            end
        end
        checks++;
        if (oFrameValid !== 1'b0) begin
            failures++;
            $display("FAIL frame_valid_in_capture actual=%b required=0", oFrameValid);
        end
        iX = 13'd143; iY = 13'd34;
        tick();
        exp_count++;
        checks++;
        if ({oProcStart, oProcGrant, oCapEnable} !== 3'b110) begin
            failures++;
            $display("FAIL process_entry actual=%b%b%b required=110", oProcStart, oProcGrant, oCapEnable);
        end
        iProcDone = 1'b1;
        iX = 13'd10; iY = 13'd200;
        tick();
        iProcDone = 1'b0;
        checks++;
        if ({oProcGrant, oProcStart} !== 2'b10) begin
            failures++;
            $display("FAIL done_on_entry_ignored actual=%b%b required=10", oProcGrant, oProcStart);
        end
        tick();
        checks++;
        if (oFrameCount !== 8'(exp_count) || oFrameValid !== 1'b1 || starts != 1) begin
            failures++;
            $display("FAIL first_capture actual=cnt%0d/valid%b/starts%0d required=cnt%0d/valid1/starts1",
                     oFrameCount, oFrameValid, starts, exp_count);
        end
    endtask

    task automatic test_done_rearm();
        iProcDone = 1'b1;
        tick();
        iProcDone = 1'b0;
        checks++;
        if ({oProcGrant, oCapEnable} !== 2'b00) begin
            failures++;
            $display("FAIL done_to_skip actual=%b%b required=00", oProcGrant, oCapEnable);
        end
        repeat (SKIP + 1) sof_frame($urandom_range(1, 4));
        checks++;
        if (oCapEnable !== 1'b1) begin
            failures++;
            $display("FAIL second_capture_enable actual=%b required=1", oCapEnable);
        end
        sof_frame(1);
        exp_count++;
        iArm = 1'b0;
        tick();
        checks++;
        if (oProcGrant !== 1'b1 || oFrameCount !== 8'(exp_count) || starts != 2) begin
            failures++;
            $display("FAIL second_capture actual=grant%b/cnt%0d/starts%0d required=grant1/cnt%0d/starts2",
                     oProcGrant, oFrameCount, starts, exp_count);
        end
        iProcDone = 1'b1;
        tick();
        iProcDone = 1'b0;
        repeat (SKIP + 2) sof_frame(1);
        checks++;
        if ({oProcGrant, oCapEnable} !== 2'b00) begin
            failures++;
            $display("FAIL done_unarmed_idle actual=%b%b required=00", oProcGrant, oCapEnable);
        end
    endtask

    task automatic test_mem_mux();
        logic        cw, pw;
        logic [14:0] ca, pa;
        logic [9:0]  cd, pd;
        arm_to_capture();
        for (int i = 0; i < 24; i++) begin
            cw = 1'($urandom); ca = 15'($urandom_range(0, DEPTH - 1)); cd = 10'($urandom);
            pw = 1'($urandom); pa = 15'($urandom_range(0, DEPTH - 1)); pd = 10'($urandom);
            if (i == 0) begin
                cw = 1'b1; ca = 15'd100; cd = 10'h3FF; pw = 1'b1;
            end
            iCapWE = cw; iCapAddr = ca; iCapData = cd;
            iProcWE = pw; iProcAddr = pa; iProcData = pd;
            tick();
            checks++;
            if ({oMemWE, oMemAddr, oMemData} !== {cw, ca, cd}) begin
                failures++;
                $display("FAIL mux_capture%0d actual=%b/%0d/%h required=%b/%0d/%h", i, oMemWE, oMemAddr, oMemData, cw, ca, cd);
            end
        end
        iCapWE = 1'b0; iProcWE = 1'b0;
        sof_frame(1);
        exp_count++;
        for (int i = 0; i < 24; i++) begin
            cw = 1'($urandom); ca = 15'($urandom_range(0, DEPTH - 1)); cd = 10'($urandom);
            pw = 1'($urandom); pa = 15'($urandom_range(0, DEPTH - 1)); pd = 10'($urandom);
            iCapWE = cw; iCapAddr = ca; iCapData = cd;
            iProcWE = pw; iProcAddr = pa; iProcData = pd;
            tick();
            checks++;
            if ({oMemWE, oMemAddr, oMemData} !== {pw, pa, pd}) begin
                failures++;
                $display("FAIL mux_process%0d actual=%b/%0d/%h required=%b/%0d/%h", i, oMemWE, oMemAddr, oMemData, pw, pa, pd);
            end
        end
        iArm = 1'b0;
        iProcDone = 1'b1;
        tick();
        iProcDone = 1'b0;
        for (int i = 0; i < 6; i++) begin
            iCapWE = 1'b1; iCapAddr = 15'($urandom_range(0, DEPTH - 1)); iCapData = 10'($urandom);
            iProcWE = 1'b1; iProcAddr = 15'($urandom_range(0, DEPTH - 1)); iProcData = 10'($urandom);
            tick();
            checks++;
            if ({oMemWE, oMemAddr, oMemData} !== '0) begin
                failures++;
                $display("FAIL mux_idle%0d actual=%b/%0d/%h required=0/0/0", i, oMemWE, oMemAddr, oMemData);
            end
        end
        iCapWE = 1'b0; iProcWE = 1'b0;
        checks++;
        if (oLed !== 1'b0 || oFrameCount !== 8'(exp_count)) begin
            failures++;
            $display("FAIL mux_end actual=led%b/cnt%0d required=led0/cnt%0d", oLed, oFrameCount, exp_count);
        end
    endtask

    task automatic test_guard_abort();
        arm_to_capture();
        iCapWE = 1'b1; iCapAddr = 15'(DEPTH); iCapData = 10'h155;
        tick();
        iCapWE = 1'b0;
        checks++;
        if (oMemWE !== 1'b0 || oLed !== 1'b1) begin
            failures++;
            $display("FAIL addr_guard actual=we%b/led%b required=we0/led1", oMemWE, oLed);
        end
        repeat (3) tick();
        iArm = 1'b0;
        iX = 13'd143; iY = 13'd34;
        tick();
        iX = 13'd10; iY = 13'd200;
        tick();
        checks++;
        if ({oCapEnable, oProcGrant, oFrameValid, oLed} !== 4'b0001 || oFrameCount !== 8'(exp_count)) begin
            failures++;
            $display("FAIL abort_wins actual=%b%b%b%b/cnt%0d required=0001/cnt%0d",
                     oCapEnable, oProcGrant, oFrameValid, oLed, oFrameCount, exp_count);
        end
        iArm = 1'b1;
        tick();
        sof_frame(2);
        sof_frame(3);
        iArm = 1'b0;
        tick();
        iArm = 1'b1;
        tick();
        repeat (SKIP) sof_frame($urandom_range(1, 4));
        checks++;
        if (oCapEnable !== 1'b0) begin
            failures++;
            $display("FAIL skip_restart_early actual=%b required=0", oCapEnable);
        end
        sof_frame(4);
        checks++;
        if (oCapEnable !== 1'b1) begin
            failures++;
            $display("FAIL skip_restart_capture actual=%b required=1", oCapEnable);
        end
        iArm = 1'b0;
        tick();
        checks++;
        if ({oCapEnable, oFrameValid, oLed} !== 3'b001) begin
            failures++;
            $display("FAIL abort_mid_capture actual=%b%b%b required=001", oCapEnable, oFrameValid, oLed);
        end
    endtask

    task automatic test_reset_mid_capture();
        arm_to_capture();
        @(posedge iCLK);
        #3;
        iRST = 1'b1;
        #1;
        checks++;
        if ({oCapEnable, oProcGrant, oProcStart, oFrameValid, oFrameCount, oMemAddr, oMemData, oMemWE, oLed} !== '0) begin
            failures++;
            $display("FAIL async_reset actual=%b/%b/%b/%b/%0d/%0d/%0d/%b/%b required=all_zero",
                     oCapEnable, oProcGrant, oProcStart, oFrameValid, oFrameCount, oMemAddr, oMemData, oMemWE, oLed);
        end
        exp_count = 0;
        iArm = 1'b0;
        repeat (2) tick();
        iRST = 1'b0;
        repeat (2) tick();
        checks++;
        if (oFrameCount !== 8'(exp_count) || oCapEnable !== 1'b0 || oLed !== 1'b0) begin
            failures++;
            $display("FAIL after_reset actual=cnt%0d/cap%b/led%b required=cnt0/cap0/led0", oFrameCount, oCapEnable, oLed);
        end
    endtask

`ifdef FRAME_CAPTURE_PROC_TIMEOUT_EN
    task automatic test_timeout();
        arm_to_capture();
        sof_frame(1);
        exp_count++;
        iArm = 1'b0;
        for (int i = 1; i <= TMO; i++) begin
            sof_frame($urandom_range(1, 3));
            checks++;
            if (oProcGrant !== (i < TMO)) begin
                failures++;
                $display("FAIL timeout_grant_sof%0d actual=%b required=%b", i, oProcGrant, (i < TMO));
            end
        end
        checks++;
        if ({oLed, oFrameValid} !== 2'b10 || oFrameCount !== 8'(exp_count)) begin
            failures++;
            $display("FAIL timeout_flags actual=led%b/valid%b/cnt%0d required=led1/valid0/cnt%0d",
                     oLed, oFrameValid, oFrameCount, exp_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_skip_capture();
        test_done_rearm();
        test_mem_mux();
        test_guard_abort();
        test_reset_mid_capture();
`ifdef FRAME_CAPTURE_PROC_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
